// File: rtl/axis_pkg.sv
// ============================================================================
// Module : axis_pkg
// Desc   : Shared types and helpers for the AXIS packet generator.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axis_pkg;

    localparam int unsigned MAX_BPB = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } pkt_gen_state_t;

    // Remainder 0 means the final beat is full.
    function automatic logic [MAX_BPB-1:0] keep_mask(input int unsigned rem,
                                                     input int unsigned bpb);
        logic [MAX_BPB-1:0] m;
        for (int unsigned i = 0; i < MAX_BPB; i++) begin
            m[i] = (rem == 0) ? (i < bpb) : (i < rem);
        end
        return m;
    endfunction

    function automatic int unsigned beats(input int unsigned len,
                                          input int unsigned bpb);
        return (len + bpb - 1) / bpb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axis_pkt_gen_if.sv
// ============================================================================
// Module : axis_pkt_gen_if
// Desc   : AXI-Stream bus bundle with master/slave views.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface axis_pkt_gen_if #(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 8,
    parameter int ID_WIDTH   = 4
) ();
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [USER_WIDTH-1:0]   tuser;
    logic [ID_WIDTH-1:0]     tid;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (
        output tvalid, tdata, tuser, tid, tkeep, tlast,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tuser, tid, tkeep, tlast,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/axis_pkt_gen_payload.sv
// ============================================================================
// Module : axis_pkt_gen_payload
// Desc   : Combinational incrementing-byte payload word for one beat.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_pkt_gen_payload #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  wire logic [7:0]            seed,
    input  wire logic [7:0]            pkt_lsb,
    input  wire logic [LEN_WIDTH-1:0]  beat,
    output logic      [DATA_WIDTH-1:0] data
);
    localparam int BPB = DATA_WIDTH / 8;

    logic [7:0] w_beat_off;
    logic [7:0] w_base;

    assign w_beat_off = 8'(32'(beat) * 32'(BPB));
    assign w_base     = seed + pkt_lsb + w_beat_off;

    genvar j;
    generate
        for (j = 0; j < BPB; j++) begin : g_byte
            assign data[8*j +: 8] = w_base + 8'(j);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/axis_pkt_gen.sv
// ============================================================================
// Module : axis_pkt_gen
// Desc   : AXI-Stream packet generator with incrementing-byte payload.
//          Optional statistics counters under `AXIS_PKT_GEN_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axis_pkt_gen
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 8,
    parameter int ID_WIDTH   = 4,
    parameter int LEN_WIDTH  = 16,
    parameter int GAP_WIDTH  = 8
) (
    input  wire logic                 CLK,
    input  wire logic                 RST,
    input  wire logic                 START,
    input  wire logic                 STOP,
    input  wire logic [LEN_WIDTH-1:0] CFG_LEN,
    input  wire logic [15:0]          CFG_COUNT,
    input  wire logic [GAP_WIDTH-1:0] CFG_GAP,
    input  wire logic [ID_WIDTH-1:0]  CFG_ID,
    input  wire logic [7:0]           CFG_SEED,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [31:0]               STAT_PKTS,
    output logic [31:0]               STAT_BEATS,
    axis_pkt_gen_if.master            m_axis
);
    localparam int unsigned BPB = DATA_WIDTH / 8;

    pkt_gen_state_t state_q, state_d;

    logic [LEN_WIDTH-1:0]  nbeats_q, nbeats_d;
    logic [LEN_WIDTH-1:0]  beat_q, beat_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           pkt_q, pkt_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            seed_q, seed_d;
    logic [BPB-1:0]        lkeep_q, lkeep_d;
    logic                  stop_pend_q, stop_pend_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [USER_WIDTH-1:0] tuser_q, tuser_d;
    logic [ID_WIDTH-1:0]   tid_q, tid_d;
    logic [BPB-1:0]        tkeep_q, tkeep_d;

    logic                  hs;
    logic                  start_acc;
    logic                  load;
    logic                  run_end;
    logic [15:0]           pkt_nxt;
    logic [LEN_WIDTH-1:0]  w_cfg_nbeats;
    logic [BPB-1:0]        w_cfg_lkeep;
    logic                  w_last_nxt;
    logic [BPB-1:0]        w_keep_nxt;
    logic [DATA_WIDTH-1:0] w_payload;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [USER_WIDTH-1:0] w_user_nxt;

    assign hs        = tvalid_q & m_axis.tready;
    assign start_acc = (state_q == IDLE) && START && (CFG_LEN != '0);
    assign pkt_nxt   = pkt_q + 16'd1;
    assign run_end   = ((count_q != 16'd0) && (pkt_nxt == count_q)) || stop_pend_q || STOP;

    assign w_cfg_nbeats = LEN_WIDTH'(beats(32'(CFG_LEN), BPB));
    assign w_cfg_lkeep  = BPB'(keep_mask(32'(CFG_LEN) % BPB, BPB));

    // Control path: decides whether a new beat is loaded onto the bus this edge.
    always_comb begin
        state_d     = state_q;
        nbeats_d    = nbeats_q;
        beat_d      = beat_q;
        count_d     = count_q;
        pkt_d       = pkt_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        id_d        = id_q;
        seed_d      = seed_q;
        lkeep_d     = lkeep_q;
        stop_pend_d = stop_pend_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_acc) begin
                    nbeats_d    = w_cfg_nbeats;
                    lkeep_d     = w_cfg_lkeep;
                    count_d     = CFG_COUNT;
                    gap_d       = CFG_GAP;
                    id_d        = CFG_ID;
                    seed_d      = CFG_SEED;
                    pkt_d       = 16'd0;
                    beat_d      = '0;
                    stop_pend_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = SEND;
                    load        = 1'b1;
                end
            end
            SEND: begin
                if (STOP) begin
                    stop_pend_d = 1'b1;
                end
                if (hs) begin
                    if (!tlast_q) begin
                        beat_d = beat_q + LEN_WIDTH'(1);
                        load   = 1'b1;
                    end else begin
                        pkt_d  = pkt_nxt;
                        beat_d = '0;
                        if (run_end) begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (gap_q != '0) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_q;
                        end else begin
                            load = 1'b1;
                        end
                    end
                end
            end
            GAP: begin
                if (stop_pend_q || STOP) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
                    state_d = SEND;
                    load    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // The beat being loaded is described entirely by the next-state registers.
    axis_pkt_gen_payload #(
        .DATA_WIDTH (DATA_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_payload (
        .seed    (seed_d),
        .pkt_lsb (pkt_d[7:0]),
        .beat    (beat_d),
        .data    (w_payload)
    );

    assign w_last_nxt = (beat_d == nbeats_d - LEN_WIDTH'(1));
    assign w_keep_nxt = w_last_nxt ? lkeep_d : {BPB{1'b1}};

    genvar j;
    generate
        for (j = 0; j < int'(BPB); j++) begin : g_mask
            assign w_data_nxt[8*j +: 8] = w_payload[8*j +: 8] & {8{w_keep_nxt[j]}};
        end
        if (USER_WIDTH <= 16) begin : g_user_narrow
            assign w_user_nxt = pkt_d[USER_WIDTH-1:0];
        end else begin : g_user_wide
            assign w_user_nxt = {{(USER_WIDTH-16){1'b0}}, pkt_d};
        end
    endgenerate

    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tid_d    = tid_q;
        tkeep_d  = tkeep_q;
        if (hs) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end
        if (load) begin
            tvalid_d = 1'b1;
            tlast_d  = w_last_nxt;
            tdata_d  = w_data_nxt;
            tuser_d  = w_user_nxt;
            tid_d    = id_d;
            tkeep_d  = w_keep_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            nbeats_q    <= '0;
            beat_q      <= '0;
            count_q     <= '0;
            pkt_q       <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            id_q        <= '0;
            seed_q      <= '0;
            lkeep_q     <= '0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tdata_q     <= '0;
            tuser_q     <= '0;
            tid_q       <= '0;
            tkeep_q     <= '0;
        end else begin
            state_q     <= state_d;
            nbeats_q    <= nbeats_d;
            beat_q      <= beat_d;
            count_q     <= count_d;
            pkt_q       <= pkt_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            id_q        <= id_d;
            seed_q      <= seed_d;
            lkeep_q     <= lkeep_d;
            stop_pend_q <= stop_pend_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tdata_q     <= tdata_d;
            tuser_q     <= tuser_d;
            tid_q       <= tid_d;
            tkeep_q     <= tkeep_d;
        end
    end

`ifdef AXIS_PKT_GEN_STATS_EN
    logic [31:0] stat_pkts_q, stat_pkts_d;
    logic [31:0] stat_beats_q, stat_beats_d;

    always_comb begin
        stat_pkts_d  = stat_pkts_q;
        stat_beats_d = stat_beats_q;
        if (start_acc) begin
            stat_pkts_d  = 32'd0;
            stat_beats_d = 32'd0;
        end else if (hs) begin
            if (stat_beats_q != 32'hFFFF_FFFF) begin
                stat_beats_d = stat_beats_q + 32'd1;
            end
            if (tlast_q && (stat_pkts_q != 32'hFFFF_FFFF)) begin
                stat_pkts_d = stat_pkts_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_pkts_q  <= 32'd0;
            stat_beats_q <= 32'd0;
        end else begin
            stat_pkts_q  <= stat_pkts_d;
            stat_beats_q <= stat_beats_d;
        end
    end

    assign STAT_PKTS  = stat_pkts_q;
    assign STAT_BEATS = stat_beats_q;
`else
    assign STAT_PKTS  = 32'd0;
    assign STAT_BEATS = 32'd0;
`endif

    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tid    = tid_q;
    assign m_axis.tkeep  = tkeep_q;

endmodule

`default_nettype wire

// File: doc/axis_pkt_gen.md
# axis_pkt_gen

AXI-Stream packet transmitter. It generates deterministic frames on an AXIS master port with configurable length, count, inter-packet gap and ID. It is the traffic source that drives the slave side of the team's AXIS FIFOs and datapath blocks in benches and in built-in self-test. Payload is a byte-incrementing pattern, so a downstream checker can predict every byte.

## Interface
Parameters:
- DATA_WIDTH, 32, TDATA width; must be a multiple of 8. BPB = DATA_WIDTH/8.
- USER_WIDTH, 8, TUSER width.
- ID_WIDTH, 4, TID width.
- LEN_WIDTH, 16, width of the packet length in bytes.
- GAP_WIDTH, 8, width of the inter-packet idle cycle count.

Ports (reset RST, synchronous, active-high; clock CLK):
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- START  in  1  one-cycle pulse; latches CFG_* and begins a run when idle
- STOP  in  1  pulse; ends the run after the current packet
- CFG_LEN  in  LEN_WIDTH  packet length in bytes; 0 is illegal
- CFG_COUNT  in  16  packets per run; 0 means continuous until STOP
- CFG_GAP  in  GAP_WIDTH  idle cycles between packets
- CFG_ID  in  ID_WIDTH  TID for the run
- CFG_SEED  in  8  payload seed byte
- BUSY  out  1  run in progress
- DONE  out  1  one-cycle pulse at run end
- STAT_PKTS  out  32  completed packets (see Configuration)
- STAT_BEATS  out  32  accepted beats (see Configuration)
- M_AXIS_TREADY  in  1
- M_AXIS_TVALID, M_AXIS_TDATA[DATA_WIDTH], M_AXIS_TUSER[USER_WIDTH], M_AXIS_TID[ID_WIDTH], M_AXIS_TKEEP[BPB], M_AXIS_TLAST  out

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE → SEND: START=1 and CFG_LEN≠0. CFG_* are latched into registers and the packet index p is cleared to 0.
  - START with CFG_LEN=0 is ignored.
  - START while BUSY is ignored.
- SEND:
  - Beats per packet = ceil(LEN/BPB).
  - Byte j of beat b of packet p = (SEED + p + b·BPB + j) mod 256. Byte j maps to TDATA[8j+7:8j].
  - TKEEP is all ones on every beat except the last. On the last beat TKEEP has the low (LEN mod BPB) bits set, or all bits set if the remainder is 0. Bytes with TKEEP=0 are driven 0.
  - TLAST is asserted on the last beat only.
  - TID = latched ID. TUSER = p[USER_WIDTH-1:0], zero-extended if USER_WIDTH>16.
  - The beat counter advances only on a handshake (TVALID & TREADY).
- When the last beat's handshake occurs, p increments (16-bit, wraps) and the block selects the next state:
  - Run finished (p+1 == COUNT with COUNT≠0, or STOP pending): go to IDLE and pulse DONE.
  - Otherwise, GAP≠0: go to GAP.
  - Otherwise: stay in SEND and start the next packet back-to-back.
- GAP: TVALID=0 for exactly GAP cycles, then SEND. A STOP seen during GAP goes to IDLE and pulses DONE.
- STOP is held as a pending flag. A packet is never truncated.
- AXIS rules:
  - Once TVALID is high it stays high, with all payload fields stable, until the handshake.
  - TVALID never depends combinationally on TREADY.

## Timing
- All outputs are registered.
- Reset values: TVALID=0, TLAST=0, TDATA/TUSER/TID/TKEEP=0, BUSY=0, DONE=0, STAT_*=0, state IDLE.
- START sampled at edge n puts the first beat on the bus (TVALID=1) after edge n. BUSY=1 from the same edge.
- Back-to-back operation: beat k+1 is presented the cycle after beat k's handshake. Sustained throughput is 1 beat/cycle under TREADY=1, including across packet boundaries when GAP=0.
- Last handshake of the run at edge m: DONE=1 and BUSY=0 after edge m, with DONE lasting one cycle. TVALID falls after edge m.
- RST mid-packet: all outputs return to reset values at the next edge. No TLAST is emitted and the partial packet is abandoned.

## Configuration
- Macro AXIS_PKT_GEN_STATS_EN.
- Defined:
  - STAT_PKTS increments on each TLAST handshake.
  - STAT_BEATS increments on each handshake.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are cleared by RST and by an accepted START.
- Undefined: the counters are not built and STAT_PKTS/STAT_BEATS are tied to 0. The ports remain so the interface is identical in both builds.

## Structure
- Shared package axis_pkg:
  - typedef enum pkt_gen_state_t {IDLE, SEND, GAP}
  - function keep_mask(rem, BPB)
  - function beats(len, BPB)
- Sub-module axis_pkt_gen_payload: combinational byte-pattern generator. Inputs are seed, p and beat index; output is the TDATA word before TKEEP masking.

## Test plan
- DATA_WIDTH=32, LEN=10, COUNT=1, SEED=0x10, TREADY=1 → 3 beats; TDATA 0x13121110, 0x17161514, 0x00001918; last TKEEP=4'b0011 with TLAST; DONE one cycle later.
- LEN=8, COUNT=3, GAP=0, TREADY=1 → 6 consecutive beats with no idle cycle; packet 1 beat 0 TDATA=0x14131211 with SEED=0x10; TUSER = 0, 1, 2 per packet.
- LEN=4, COUNT=2, GAP=3 → exactly 3 TVALID=0 cycles between the two TLAST beats.
- Random TREADY at 30% duty → TVALID never drops and payload stays stable while TVALID=1 and TREADY=0; byte stream matches the model.
- COUNT=0, STOP asserted mid-packet 5 → packet 5 completes with TLAST, then DONE; STAT_PKTS=6 (STATS_EN build).
- RST asserted during beat 2 of LEN=64 → next cycle TVALID=0 and BUSY=0; a later START with the same config replays packet 0 from SEED.
